gf2_affine_prng_core: RTL and testbench
=======================================

// Module: gf2_affine_prng_core
// PURPOSE
//  Sequential PRNG core: holds an N-bit state s(x) and, per accepted output, updates it to s' = a(x)s(x) + c(x) mod h(x) over GF(2).
//  Parametrised successor of the fixed 31-bit affine/mod datapath: a, c, h, width and seed are parameters.
//  Adds seed loading, an enable-driven FSM and a valid/ready output stream.
//  Sits between the system seed source and any consumer of GF(2^N) pseudo-random words.
// PARAMETERS
//  N        31           state/output width; deg h = N
//  A_DEG    4            degree of a(x); 1 <= A_DEG <= N-1
//  A_POLY   'h11         a(x) coefficients, A_DEG+1 bits, bit i = coeff of x^i
//  C_POLY   'h1          c(x) coefficients, N bits
//  H_POLY   'h00002109   h(x) low N bits (x^N implicit), default x^31+x^13+x^8+x^3+1
//  SEED     'h1          state loaded at reset
// PORTS
//  clk         in   1  single clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  en          in   1  1 = generate; 0 = pause after the current beat
//  seed_valid  in   1  load seed this cycle (always accepted, no ready)
//  seed        in   N  new state value
//  out_valid   out  1  out_data holds a valid word
//  out_ready   in   1  consumer accepts word when out_valid & out_ready
//  out_data    out  N  current state s(x)
//  busy        out  1  FSM not in IDLE
// BEHAVIOUR
//  - Reset (async assert, sync deassert at clk): state=SEED, FSM=IDLE, out_valid=0, busy=0; out_data mirrors state (=SEED).
//  - FSM states: IDLE, RUN, LOAD.
//    IDLE: out_valid=0. en=1 -> RUN. seed_valid=1 -> LOAD (priority over en).
//    RUN: out_valid=1, out_data=state. On handshake, state<=next(state) at that edge.
//      en=0 with no handshake pending -> IDLE; with out_valid=1 and out_ready=0 the word is held stable (AXI rule: out_data/out_valid never change until accepted) and the FSM stays in RUN even if en drops.
//      seed_valid=1 in RUN: seed wins; any handshake in that same cycle still counts as accepted for the old word, but the state takes seed, not next(state). FSM -> LOAD.
//    LOAD: one cycle, out_valid=0, state already = seed. Then en=1 -> RUN, else IDLE. seed_valid again in LOAD reloads and stays in LOAD.
//  - busy = (FSM != IDLE).
//  - Latency: seed_valid at edge k -> first word (=seed) valid after edge k+1. Throughput: one word per cycle while out_ready=1.
//  - First word after reset/seed is the seed itself; the next word is next(seed).
//  - next(): product p = a*s is N+A_DEG bits (carry-less XOR of shifted s per set bit of A_POLY).
//    Reduce from bit N+A_DEG-1 down to N: if bit set, XOR (H_POLY << (j-N)) and clear bit j.
//    Then add C_POLY (XOR). Purely combinational, one cycle, no internal pipelining.
//  - A stuck fixed point (next(s)=s) is not detected; avoid it by choice of parameters/seed.
//  - Reset mid-stream: immediate return to the reset state; no handshake is completed by that edge.
// CONFIGURATION
//  GF2_PRNG_STEP_CNT_EN defined: adds port step_cnt out 32 = number of accepted words since reset or last seed load.
//    It is cleared on reset and on seed_valid (seed wins over a simultaneous handshake) and wraps from 2^32-1 to 0.
//  Not defined: no step_cnt port and no counter logic; all other behaviour identical.
// TESTING (defaults N=31, a=x^4+1, c=1, h=x^31+x^13+x^8+x^3+1)
//  1. Reset, en=1, out_ready=1 -> words 0x00000001, 0x00000010, 0x00000111, 0x00001000, 0x00011001.
//  2. seed_valid with seed=0x40000000, then en=1 -> 1 cycle out_valid=0, then 0x40000000, 0x40010849 (reduction path).
//  3. RUN with out_ready=0 for 5 cycles and en toggled -> out_data stays 0x00000010 and out_valid stays 1; first ready -> advances to 0x00000111.
//  4. seed_valid=0x00000001 in the same cycle as a handshake on 0x00000111 -> next valid word is 0x00000001, not 0x00001000.
//  5. Assert rst_n=0 mid-stream between clock edges -> out_valid=0 immediately; after release + en=1 the sequence restarts at 0x00000001.
//  6. GF2_PRNG_STEP_CNT_EN: 4 handshakes -> step_cnt=4; seed_valid -> step_cnt=0; force the counter to 0xFFFFFFFF, one handshake -> 0.

Source files
------------

// File: rtl/gf2_affine_prng_if.sv
// Output word stream of the GF(2) affine PRNG core: valid/ready with an N-bit payload.
interface gf2_affine_prng_if #(
    parameter int unsigned N = 31
) ();
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/gf2_affine_prng_core.sv
// Sequential GF(2) PRNG: s' = a(x)s(x) + c(x) mod h(x) per accepted word, with seed load and valid/ready output.
// Optional feature: define GF2_PRNG_STEP_CNT_EN to add the 32-bit step_cnt output.
module gf2_affine_prng_core #(
    parameter int unsigned     N      = 31,
    parameter int unsigned     A_DEG  = 4,
    parameter logic [A_DEG:0]  A_POLY = (A_DEG+1)'(32'h11),
    parameter logic [N-1:0]    C_POLY = N'(32'h1),
    parameter logic [N-1:0]    H_POLY = N'(32'h0000_2109),
    parameter logic [N-1:0]    SEED   = N'(32'h1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   seed_valid,
    input  logic [N-1:0]           seed,
    gf2_affine_prng_if.master      out_if,
`ifdef GF2_PRNG_STEP_CNT_EN
    output logic [31:0]            step_cnt,
`endif
    output logic                   busy
);

    localparam int unsigned P_W = N + A_DEG;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } state_e;

    state_e       state_q;
    state_e       state_nxt;
    logic         out_valid_q;
    logic         busy_q;
    logic [N-1:0] s_q;
    logic [N-1:0] s_nxt;
    logic         hs_c;

    // Carry-less multiply by a(x), fold high bits back with h(x), then add c(x).
    function automatic logic [N-1:0] next_state(input logic [N-1:0] s);
        logic [P_W-1:0] p;
        p = '0;
        for (int unsigned i = 0; i <= A_DEG; i++) begin
            if (A_POLY[i]) p = p ^ (P_W'(s) << i);
        end
        for (int j = int'(P_W) - 1; j >= int'(N); j--) begin
            if (p[j]) p = p ^ (P_W'(H_POLY) << (j - int'(N))) ^ (P_W'(1) << j);
        end
        return p[N-1:0] ^ C_POLY;
    endfunction

    // State register; stream flags are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            out_valid_q <= (state_nxt == RUN);
            busy_q      <= (state_nxt != IDLE);
        end
    end

    // Next-state logic: seed beats everything; an unaccepted word pins the FSM in RUN.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (seed_valid)  state_nxt = LOAD;
                else if (en)     state_nxt = RUN;
            end
            RUN: begin
                if (seed_valid)  state_nxt = LOAD;
                else if (hs_c)   state_nxt = en ? RUN : IDLE;
            end
            LOAD: begin
                if (seed_valid)  state_nxt = LOAD;
                else if (en)     state_nxt = RUN;
                else             state_nxt = IDLE;
            end
            default:             state_nxt = IDLE;
        endcase
    end

    // Datapath control: load seed, or advance on an accepted word.
    always_comb begin
        hs_c  = out_valid_q & out_if.out_ready;
        s_nxt = s_q;
        if (seed_valid)  s_nxt = seed;
        else if (hs_c)   s_nxt = next_state(s_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_q <= SEED;
        else        s_q <= s_nxt;
    end

`ifdef GF2_PRNG_STEP_CNT_EN
    // Accepted-word counter; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          step_cnt <= '0;
        else if (seed_valid) step_cnt <= '0;
        else if (hs_c)       step_cnt <= step_cnt + 32'd1;
    end
`endif

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = s_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_gf2_affine_prng_core.sv
// Directed-vector bench for gf2_affine_prng_core with default parameters.
module tb_gf2_affine_prng_core;

    localparam int unsigned N = 31;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         seed_valid;
    logic [N-1:0] seed;
    logic         busy;
`ifdef GF2_PRNG_STEP_CNT_EN
    logic [31:0]  step_cnt;
`endif

    int n_checks;
    int n_errors;

    gf2_affine_prng_if #(.N(N)) bus ();

    gf2_affine_prng_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .seed_valid (seed_valid),
        .seed       (seed),
        .out_if     (bus.master),
`ifdef GF2_PRNG_STEP_CNT_EN
        .step_cnt   (step_cnt),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         en;
        logic         sv;
        logic         rdy;
        logic [N-1:0] seed;
        logic         exp_v;
        logic [N-1:0] exp_d;
        logic         exp_b;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference step via repeated multiply-by-x: a*s = x^4*s + s.
    function automatic logic [N-1:0] mulx(input logic [N-1:0] s);
        return {s[N-2:0], 1'b0} ^ (s[N-1] ? 31'h0000_2109 : 31'h0);
    endfunction

    function automatic logic [N-1:0] model_next(input logic [N-1:0] s);
        return mulx(mulx(mulx(mulx(s)))) ^ s ^ 31'h1;
    endfunction

    initial begin
        logic [N-1:0] exp_s;
        logic         hs;
        n_checks = 0;
        n_errors = 0;

        vecs[0]  = '{1'b1, 1'b0, 1'b1, 31'h0,        1'b1, 31'h1,        1'b1};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 31'h0,        1'b1, 31'h10,       1'b1};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 31'h0,        1'b1, 31'h111,      1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 31'h0,        1'b1, 31'h1000,     1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 31'h0,        1'b1, 31'h11001,    1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 31'h1,        1'b0, 31'h1,        1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 31'h0,        1'b1, 31'h1,        1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 31'h0,        1'b1, 31'h10,       1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 31'h0,        1'b1, 31'h10,       1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 31'h0,        1'b1, 31'h10,       1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 31'h0,        1'b1, 31'h10,       1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 31'h0,        1'b1, 31'h10,       1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 31'h0,        1'b1, 31'h10,       1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 31'h0,        1'b1, 31'h111,      1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 31'h1,        1'b0, 31'h1,        1'b1};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 31'h0,        1'b1, 31'h1,        1'b1};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 31'h0,        1'b1, 31'h10,       1'b1};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 31'h0,        1'b0, 31'h111,      1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 31'h0,        1'b0, 31'h111,      1'b0};
        vecs[19] = '{1'b1, 1'b1, 1'b1, 31'h40000000, 1'b0, 31'h40000000, 1'b1};
        vecs[20] = '{1'b1, 1'b0, 1'b1, 31'h0,        1'b1, 31'h40000000, 1'b1};
        vecs[21] = '{1'b1, 1'b0, 1'b1, 31'h0,        1'b1, 31'h40010849, 1'b1};
        vecs[22] = '{1'b1, 1'b1, 1'b1, 31'h123,      1'b0, 31'h123,      1'b1};
        vecs[23] = '{1'b1, 1'b1, 1'b1, 31'h40000000, 1'b0, 31'h40000000, 1'b1};
        vecs[24] = '{1'b0, 1'b0, 1'b1, 31'h0,        1'b0, 31'h40000000, 1'b0};
        vecs[25] = '{1'b1, 1'b0, 1'b1, 31'h0,        1'b1, 31'h40000000, 1'b1};
        vecs[26] = '{1'b1, 1'b0, 1'b1, 31'h0,        1'b1, 31'h40010849, 1'b1};

        rst_n         = 1'b0;
        en            = 1'b0;
        seed_valid    = 1'b0;
        seed          = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("reset_valid", 32'(bus.out_valid), 32'h0);
        chk("reset_data",  32'(bus.out_data),  32'h1);
        chk("reset_busy",  32'(busy),          32'h0);
`ifdef GF2_PRNG_STEP_CNT_EN
        chk("reset_cnt",   step_cnt,           32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table: reset sequence, seed/reduction path, stall with en toggling, seed vs handshake.
        for (int i = 0; i < NV; i++) begin
            en            = vecs[i].en;
            seed_valid    = vecs[i].sv;
            bus.out_ready = vecs[i].rdy;
            seed          = vecs[i].seed;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_v));
            chk($sformatf("vec%0d_data", i),  32'(bus.out_data),  32'(vecs[i].exp_d));
            chk($sformatf("vec%0d_busy", i),  32'(busy),          32'(vecs[i].exp_b));
        end

        // Stream with random back-pressure against the reference model.
        seed_valid = 1'b1;
        seed       = 31'h05A5_A5A5;
        en         = 1'b1;
        tick();
        seed_valid = 1'b0;
        exp_s      = 31'h05A5_A5A5;
        tick();
        for (int i = 0; i < 40; i++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            hs = bus.out_valid & bus.out_ready;
            tick();
            if (hs) exp_s = model_next(exp_s);
            chk($sformatf("rand%0d_data", i), 32'(bus.out_data), 32'(exp_s));
            chk($sformatf("rand%0d_valid", i), 32'(bus.out_valid), 32'h1);
        end

`ifdef GF2_PRNG_STEP_CNT_EN
        // Counter: clear on seed (beats handshake), count handshakes, wrap.
        bus.out_ready = 1'b1;
        seed_valid = 1'b1;
        seed       = 31'h1;
        tick();
        seed_valid = 1'b0;
        chk("cnt_seed_clear", step_cnt, 32'h0);
        tick();
        repeat (4) tick();
        chk("cnt_four", step_cnt, 32'd4);
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        chk("cnt_seed_hs", step_cnt, 32'h0);
        tick();
        bus.out_ready = 1'b0;
        @(negedge clk);
        force dut.step_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.step_cnt;
        bus.out_ready = 1'b1;
        tick();
        chk("cnt_wrap", step_cnt, 32'h0);
`endif

        // Asynchronous reset between edges, then restart.
        en            = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'h0);
        chk("arst_data",  32'(bus.out_data),  32'h1);
        chk("arst_busy",  32'(busy),          32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("restart0_valid", 32'(bus.out_valid), 32'h1);
        chk("restart0_data",  32'(bus.out_data),  32'h1);
        tick();
        chk("restart1_data",  32'(bus.out_data),  32'h10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
